// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event queue: key indices, event type
// encodings, the millisecond tick divider and the FIFO entry layout.
// Optional feature macro: KEY_EVT_TIMESTAMP_EN (adds a 16-bit timestamp
// to every FIFO entry).
package key_evt_pkg;

    localparam int NUM_KEYS = 10;

    localparam logic [3:0] KEY_LEFT  = 4'd0;
    localparam logic [3:0] KEY_RIGHT = 4'd1;
    localparam logic [3:0] KEY_UP    = 4'd2;
    localparam logic [3:0] KEY_DOWN  = 4'd3;
    localparam logic [3:0] KEY_D     = 4'd4;
    localparam logic [3:0] KEY_F     = 4'd5;
    localparam logic [3:0] KEY_J     = 4'd6;
    localparam logic [3:0] KEY_K     = 4'd7;
    localparam logic [3:0] KEY_ENTER = 4'd8;
    localparam logic [3:0] KEY_ESC   = 4'd9;

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_RELEASE = 2'b01;
    localparam logic [1:0] EVT_REPEAT  = 2'b10;

    // clk cycles per millisecond tick of the timestamp counter
    localparam int TICK_DIV = 100000;

    typedef struct packed {
        logic [3:0]  key;
        logic [1:0]  typ;
`ifdef KEY_EVT_TIMESTAMP_EN
        logic [15:0] ts;
`endif
    } evt_entry_t;

    localparam int ENTRY_W = $bits(evt_entry_t);

    // One-hot vector with only bit k set
    function automatic logic [NUM_KEYS-1:0] key_onehot(input logic [3:0] k);
        key_onehot = {{(NUM_KEYS-1){1'b0}}, 1'b1} << k;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through FIFO with occupancy count. A push is accepted
// when not full, or when full and a pop happens in the same cycle.
// A pop on an empty FIFO is ignored.
module key_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop_req,
    output logic [WIDTH-1:0]       rdata,
    output logic                   valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign valid   = (cnt != CW'(0));
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop_req & valid;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage, pointers (wrap naturally at power-of-2 depth) and count
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= {AW{1'b0}};
            rd_ptr <= {AW{1'b0}};
            cnt    <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Key event queue: turns ten level-held key signals into press / repeat /
// release events queued in a FWFT FIFO, plus one-cycle press pulses.
// Arrow keys (REPEAT_MASK) auto-repeat via one shared counter that follows
// the most recently pressed repeatable key.
// Optional feature macro: KEY_EVT_TIMESTAMP_EN (millisecond timestamp per
// event, presented on evt_time).
module key_event_queue
    import key_evt_pkg::*;
#(
    parameter int                  DEPTH         = 8,
    parameter int                  REPEAT_DELAY  = 50000000,
    parameter int                  REPEAT_PERIOD = 10000000,
    parameter logic [NUM_KEYS-1:0] REPEAT_MASK   = 10'b0000001111
`ifdef KEY_EVT_TIMESTAMP_EN
    ,
    parameter int                  TICK_DIV_CYC  = TICK_DIV,
    parameter logic [15:0]         TIME_INIT     = 16'd0
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_KEYS-1:0]    keys_lvl,
    output logic [NUM_KEYS-1:0]    press_pulse,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [3:0]             evt_key,
    output logic [1:0]             evt_type,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                   ovf,
    input  logic                   clr_ovf
`ifdef KEY_EVT_TIMESTAMP_EN
    ,
    output logic [15:0]            evt_time
`endif
);

    localparam logic [31:0]         DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0]         PERIOD_LAST = 32'(REPEAT_PERIOD - 1);
    localparam logic [NUM_KEYS-1:0] NO_KEYS     = {NUM_KEYS{1'b0}};

    logic [NUM_KEYS-1:0] k_q, k_p, rise, fall;
    logic [NUM_KEYS-1:0] press_pend, rep_pend, rel_pend;
    logic [NUM_KEYS-1:0] pp_eff, rp_eff, rl_eff, rep_set;
    logic [NUM_KEYS-1:0] pp_nxt, rp_nxt, rl_nxt, sel_onehot;
    logic                mask_rise_any;
    logic [3:0]          mask_rise_key;
    logic                rep_active, rep_in_period, rep_due, rep_fire;
    logic [3:0]          rep_key;
    logic [31:0]         rep_cnt;
    logic                has_sel, push, pop, wr_ok, drop;
    logic [3:0]          sel_key;
    logic [1:0]          sel_type;
    logic                fifo_valid, fifo_full;
    evt_entry_t          wr_entry, head;

`ifdef KEY_EVT_TIMESTAMP_EN
    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV_CYC - 1);
    logic [31:0] tick_cnt;
    logic [15:0] ms_cnt;

    // Free-running millisecond counter, wraps 65535 -> 0
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= 32'd0;
            ms_cnt   <= TIME_INIT;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= 32'd0;
            ms_cnt   <= ms_cnt + 16'd1;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

    assign evt_time = fifo_valid ? head.ts : 16'd0;
`endif

    // Input register, previous-level history and press pulse (pulse lines up with rise)
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q         <= NO_KEYS;
            k_p         <= NO_KEYS;
            press_pulse <= NO_KEYS;
        end else begin
            k_q         <= keys_lvl;
            k_p         <= k_q;
            press_pulse <= keys_lvl & ~k_q;
        end
    end

    // Edges, repeat due-check, one-per-cycle arbitration and next pending flags
    always_comb begin
        rise = k_q & ~k_p;
        fall = ~k_q & k_p;

        mask_rise_any = 1'b0;
        mask_rise_key = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            mask_rise_any = (rise[i] && REPEAT_MASK[i]) ? 1'b1  : mask_rise_any;
            mask_rise_key = (rise[i] && REPEAT_MASK[i]) ? 4'(i) : mask_rise_key;
        end

        // A fresh repeatable press restarts tracking, so it overrides a due repeat
        rep_due  = rep_in_period ? (rep_cnt == PERIOD_LAST) : (rep_cnt == DELAY_LAST);
        rep_fire = rep_active & k_q[rep_key] & ~mask_rise_any & rep_due;
        rep_set  = rep_fire ? key_onehot(rep_key) : NO_KEYS;

        // New edges are visible to the arbiter in the same cycle they are detected
        pp_eff = press_pend | rise;
        rp_eff = (rep_pend & ~fall) | rep_set;
        rl_eff = rel_pend | fall;

        has_sel = 1'b0;
        sel_key = 4'd0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            has_sel = (pp_eff[i] | rp_eff[i] | rl_eff[i]) ? 1'b1  : has_sel;
            sel_key = (pp_eff[i] | rp_eff[i] | rl_eff[i]) ? 4'(i) : sel_key;
        end

        if (pp_eff[sel_key]) begin
            sel_type = EVT_PRESS;
        end else if (rp_eff[sel_key]) begin
            sel_type = EVT_REPEAT;
        end else begin
            sel_type = EVT_RELEASE;
        end

        sel_onehot = key_onehot(sel_key);
        pop        = fifo_valid & evt_ready;
        wr_ok      = ~fifo_full | pop;
        push       = has_sel & wr_ok;

        pp_nxt = pp_eff & ~((push && sel_type == EVT_PRESS)   ? sel_onehot : NO_KEYS);
        rp_nxt = rp_eff & ~((push && sel_type == EVT_REPEAT)  ? sel_onehot : NO_KEYS);
        rl_nxt = rl_eff & ~((push && sel_type == EVT_RELEASE) ? sel_onehot : NO_KEYS);

        // Coalesced repeats are intentionally not counted as lost events
        drop = (|(rise & press_pend)) | (|(fall & rel_pend));

        wr_entry     = '{default: 1'b0};
        wr_entry.key = sel_key;
        wr_entry.typ = sel_type;
`ifdef KEY_EVT_TIMESTAMP_EN
        wr_entry.ts  = ms_cnt;
`endif
    end

    // Pending flags and sticky overflow (a drop beats a same-cycle clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            press_pend <= NO_KEYS;
            rep_pend   <= NO_KEYS;
            rel_pend   <= NO_KEYS;
            ovf        <= 1'b0;
        end else begin
            press_pend <= pp_nxt;
            rep_pend   <= rp_nxt;
            rel_pend   <= rl_nxt;
            ovf        <= drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf);
        end
    end

    // Shared auto-repeat counter following the latest repeatable press
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_active    <= 1'b0;
            rep_in_period <= 1'b0;
            rep_key       <= 4'd0;
            rep_cnt       <= 32'd0;
        end else if (mask_rise_any) begin
            rep_active    <= 1'b1;
            rep_in_period <= 1'b0;
            rep_key       <= mask_rise_key;
            rep_cnt       <= 32'd0;
        end else if (rep_active && fall[rep_key]) begin
            rep_active    <= 1'b0;
            rep_in_period <= 1'b0;
            rep_cnt       <= 32'd0;
        end else if (rep_active && rep_due) begin
            rep_in_period <= 1'b1;
            rep_cnt       <= 32'd0;
        end else if (rep_active) begin
            rep_cnt       <= rep_cnt + 32'd1;
        end else begin
            rep_cnt       <= rep_cnt;
        end
    end

    key_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wdata   (wr_entry),
        .pop_req (evt_ready),
        .rdata   (head),
        .valid   (fifo_valid),
        .full    (fifo_full),
        .cnt     (fifo_cnt)
    );

    assign evt_valid = fifo_valid;
    assign evt_key   = fifo_valid ? head.key : 4'd0;
    assign evt_type  = fifo_valid ? head.typ : 2'd0;

endmodule
